// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: PWM brightness, leading-zero
// suppression and frame-synchronous (tear-free) loading of display data.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk_7seg,
    input  logic                    Rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sev_out,
    output logic                    dp_out,
    output logic                    load_ack,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] PHASE_MAX = '1;
    localparam logic                INV       = (ACTIVE_LOW != 0);

    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_W-1:0]     phase;
    logic [BRIGHT_W-1:0]     bright_q;
    logic [4*NUM_DIGITS-1:0] act_data, pend_data;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
    logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
    logic                    pend_valid;

    logic                    slot_end;
    logic                    last_clk;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              cur_nib;
    logic                    lit_phase;
    logic                    seg_on;
    logic                    dp_on;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h70;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    assign slot_end   = (phase == PHASE_MAX);
    assign last_clk   = slot_end && (idx == LAST_IDX);
    assign frame_done = last_clk;

    // Suppression runs from the top digit down and stops at the first nonzero nibble.
    always_comb begin
        supp     = '0;
        zero_run = lz_suppress;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (act_data[4*i +: 4] == 4'h0);
            supp[i]  = zero_run;
        end
    end

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        cur_nib     = act_data[{idx, 2'b00} +: 4];
        lit_phase   = (phase <= bright_q);
        seg_on      = lit_phase && !act_blank[idx] && !supp[idx];
        dp_on       = lit_phase && !act_blank[idx] && act_dp[idx];
        an_next     = (seg_on || dp_on) ? onehot : '0;
        seg_next    = seg_on ? hex_to_seg(cur_nib) : 7'h00;
    end

    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            idx        <= '0;
            phase      <= '0;
            bright_q   <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            load_ack   <= 1'b0;
            an         <= {NUM_DIGITS{INV}};
            sev_out    <= {7{INV}};
            dp_out     <= INV;
        end else begin
            phase <= phase + 1'b1;
            if (slot_end)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (phase == '0)
                bright_q <= brightness;

            // Active data only moves on the last clock of a frame, so a frame never tears.
            if (last_clk && load) begin
                act_data   <= data_in;
                act_dp     <= dp_in;
                act_blank  <= blank_in;
                pend_valid <= 1'b0;
            end else if (last_clk && pend_valid) begin
                act_data   <= pend_data;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend_valid <= 1'b1;
            end
            load_ack <= last_clk && (load || pend_valid);

            an      <= an_next ^ {NUM_DIGITS{INV}};
            sev_out <= seg_next ^ {7{INV}};
            dp_out  <= dp_on ^ INV;
        end
    end

endmodule
